// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   NRP combinational read ports and two synchronous write ports.
//   Register 0 is hardwired to zero. On an address clash, write port 1 wins.
//   A scrub sequencer zeroes x1..x(NREG-1) after reset or on clr_req.
//   ready is high once the scrub has finished.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to
//   the read ports (RUN state only).
// Handshake: there is no valid/ready flow control. ready is a status level only.
//   While ready=0 the file ignores writes and clr_req, and every read returns 0.
module regfile_mp #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRP  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   rs,
    output logic [NRP*XLEN-1:0] rdata,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                clr_req,
    output logic                ready
);

    localparam logic [0:0] SCRUB = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]      r_state;
    logic [AW-1:0]   r_scnt;
    logic            r_ready;
    logic [XLEN-1:0] r_mem [1:NREG-1];

    logic w_scrub;
    logic w_run;
    logic w_wr0;
    logic w_wr1;

    assign w_scrub = (r_state == SCRUB);
    assign w_run   = (r_state == RUN);
    // Writes to x0 and writes issued while scrubbing are discarded.
    assign w_wr0   = we0 && (wa0 != '0) && w_run;
    assign w_wr1   = we1 && (wa1 != '0) && w_run;
    assign ready   = r_ready;

    // Sequencer: scrub x1..x(NREG-1) once, then run until clr_req or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCRUB;
            r_scnt  <= AW'(1);
            r_ready <= 1'b0;
        end else if (r_state == SCRUB) begin
            if (r_scnt == AW'(NREG - 1)) begin
                r_state <= RUN;
                r_ready <= 1'b1;
                r_scnt  <= AW'(1);
            end else begin
                r_scnt  <= r_scnt + AW'(1);
            end
        end else if (clr_req) begin
            r_state <= SCRUB;
            r_ready <= 1'b0;
            r_scnt  <= AW'(1);
        end
    end

    // Storage update. The scrub takes precedence; otherwise port 1 wins over port 0.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREG; i++) begin
            if (w_scrub) begin
                if (r_scnt == AW'(i)) r_mem[i] <= '0;
            end else if (w_wr1 && (wa1 == AW'(i))) begin
                r_mem[i] <= wd1;
            end else if (w_wr0 && (wa0 == AW'(i))) begin
                r_mem[i] <= wd0;
            end
        end
    end

    // Independent read ports.
    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_val;

        assign w_addr = rs[p*AW +: AW];

        // Read mux: storage, optionally forwarded write data, forced to 0 for x0 and while scrubbing.
        always_comb begin
            w_val = '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_addr == AW'(i)) w_val = r_mem[i];
            end
`ifdef REGFILE_BYPASS_EN
            if (w_run && (w_addr != '0)) begin
                if (we1 && (wa1 == w_addr))      w_val = wd1;
                else if (we0 && (wa0 == w_addr)) w_val = wd0;
            end
`endif
            if (!w_run || (w_addr == '0)) w_val = '0;
        end

        assign rdata[p*XLEN +: XLEN] = w_val;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the multi-issue / pipelined core generation. It provides NRP asynchronous read ports and two synchronous write ports, with a hardwired-zero register 0 and defined write-write priority. A built-in scrub sequencer clears every register after reset or on request, and signals when the file is usable. It replaces the fixed 32x32, 2R1W register file in the decode stage.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREG, 32, number of registers; power of two, ≥4
- NRP, 2, number of read ports (1..6)
- AW, $clog2(NREG), derived address width; not overridden
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs  in  NRP*AW  read addresses; port p uses bits [p*AW +: AW]
- rdata  out  NRP*XLEN  read data; port p uses bits [p*XLEN +: XLEN]
- we0  in  1  write enable, port 0
- wa0  in  AW  write address, port 0
- wd0  in  XLEN  write data, port 0
- we1  in  1  write enable, port 1 (younger instruction)
- wa1  in  AW  write address, port 1
- wd1  in  XLEN  write data, port 1
- clr_req  in  1  one-cycle request to re-run the scrub
- ready  out  1  high when the file accepts writes and returns stored data

## Operation
- Storage: registers 1..NREG-1, XLEN bits each. Register 0 has no storage and always reads 0.
- FSM states are SCRUB and RUN. A counter scnt (AW bits) tracks the scrub position.
- Reset (rst_n=0, asynchronous): state=SCRUB, scnt=1, ready=0. Storage contents are undefined until the scrub completes.
- SCRUB: each rising edge writes x[scnt]<=0 and increments scnt.
  - On the edge that clears NREG-1: state→RUN, ready→1, scnt→1.
  - we0, we1 and clr_req are ignored.
  - All rdata ports return 0.
- RUN writes:
  - A port writes if weN=1 and waN≠0.
  - If both ports are valid and wa0==wa1, port 1's data is stored and port 0's is dropped.
  - Writes to address 0 are discarded.
- RUN clr_req=1: state→SCRUB, ready→0, scnt=1. Writes presented in that same cycle are still performed. The scrub then overwrites them.
- Reads are combinational in rs and storage:
  - rs==0 → 0.
  - Otherwise the value is the stored register, modified by the bypass (see Configuration).
- Each read port is independent. Any number of ports may address the same register.

## Timing
- Read latency: combinational, zero cycles.
- Write latency: data is visible in storage after the rising edge at which it is presented.
- Scrub duration: NREG-1 rising edges after rst_n deasserts or after the clr_req edge. ready rises on the final scrub edge; for NREG=32, that is 31 edges.
- ready is registered and glitch-free. Reset value is 0.
- rdata during reset is 0.
- Reset asserted mid-scrub or mid-RUN restarts the scrub from scnt=1. No partial state is retained.
- clr_req during SCRUB does not restart or extend the scrub.

## Configuration
- REGFILE_BYPASS_EN defined: write-through bypass, applied only in RUN.
  - A read of address a returns wd1 if we1 && wa1==a && a≠0.
  - Otherwise it returns wd0 if we0 && wa0==a && a≠0.
  - Otherwise it returns storage.
  - The bypass follows the same write-write priority as storage.
- REGFILE_BYPASS_EN undefined: reads return storage only. Same-cycle write data is visible from the next cycle.
- Write behaviour, scrub and ready are identical in both builds.

## Test plan
- Reset scrub: preload is irrelevant. Release rst_n with NREG=32, then read all addresses on every port.
  - ready=0 for 30 edges and rises on the 31st.
  - Every register reads 0 afterwards.
- Basic write/read: in RUN, we0=1, wa0=5, wd0=0xDEADBEEF. Next cycle rs(port0)=5, rs(port1)=5: both return 0xDEADBEEF.
- Conflict and x0:
  - Same cycle: we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22. Next cycle x7 reads 0x22.
  - we1 wa1=0 wd1=0xFFFF_FFFF: x0 still reads 0.
- Bypass:
  - With REGFILE_BYPASS_EN: we1 wa1=3 wd1=0xA5A5A5A5 and rs=3 in the same cycle → rdata=0xA5A5A5A5 in that cycle.
  - Without it: the old value is returned that cycle and 0xA5A5A5A5 the next.
- clr_req mid-run:
  - Fill x1..x31 with nonzero values, then pulse clr_req. ready→0 next edge.
  - A write during the scrub to x9 is ignored.
  - After 31 edges ready=1 and all registers read 0.
- Reset mid-scrub: assert rst_n low at scrub edge 10, release 2 cycles later. ready rises exactly 31 edges after release and all registers read 0.
